// File: rtl/double_to_long_pkg.sv
// Shared constants and types for the double-to-long converter.
package double_to_long_pkg;

  localparam int DOUBLE_W      = 64;
  localparam int LONG_W        = 64;
  localparam int DOUBLE_MANT_W = 52;
  localparam int DOUBLE_EXP_W  = 11;

  localparam logic signed [11:0] DOUBLE_BIAS = 12'sd1023;
  localparam logic [LONG_W-1:0]  LONG_MIN    = 64'h8000_0000_0000_0000;

  // Unbiased exponent at which the mantissa is fully aligned as an integer
  localparam logic signed [11:0] E_ALIGNED   = 12'sd63;
  localparam logic signed [11:0] E_LAST_STEP = 12'sd62;

  typedef enum logic [2:0] {
    get_a         = 3'd0,
    unpack        = 3'd1,
    special_cases = 3'd2,
    convert       = 3'd3,
    pack          = 3'd4,
    put_z         = 3'd5
  } state_t;

  // Remove the exponent bias, giving a signed 12-bit unbiased exponent
  function automatic logic signed [11:0] unbias(input logic [DOUBLE_EXP_W-1:0] exp_field);
    return $signed({1'b0, exp_field}) - DOUBLE_BIAS;
  endfunction

endpackage

// File: rtl/double_to_long.sv
// IEEE-754 double to signed 64-bit integer, truncating toward zero.
// Registered stb/ack handshake on both sides; bit-serial alignment shifter.
module double_to_long
  import double_to_long_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [DOUBLE_W-1:0] input_a,
  input  logic                input_a_stb,
  output logic                input_a_ack,
  output logic [LONG_W-1:0]   output_z,
  output logic                output_z_stb,
  input  logic                output_z_ack
);

  state_t state_q, state_d;

  logic [DOUBLE_W-1:0] a_q, a_d;
  logic [LONG_W-1:0]   m_q, m_d;
  logic [LONG_W-1:0]   z_d;
  logic signed [11:0]  e_q, e_d;
  logic                s_q, s_d;
  logic                ack_d, stb_d;

  logic a_take, z_give;
  logic exit_zero, exit_ovf;

  assign a_take    = input_a_ack & input_a_stb;
  assign z_give    = output_z_stb & output_z_ack;
  assign exit_zero = (a_q[DOUBLE_W-2 -: DOUBLE_EXP_W] == '0) || (e_q < 12'sd0);
  assign exit_ovf  = (e_q >= E_ALIGNED);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= get_a;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      get_a:         if (a_take) state_d = unpack;
      unpack:        state_d = special_cases;
      special_cases: begin
        if (exit_zero || exit_ovf)   state_d = put_z;
        else if (e_q == E_LAST_STEP) state_d = pack;
        else                         state_d = convert;
      end
      convert:       if (e_q >= E_LAST_STEP) state_d = pack;
      pack:          state_d = put_z;
      put_z:         if (z_give) state_d = get_a;
      default:       state_d = get_a;
    endcase
  end

  // Datapath and handshake next values for each state
  always_comb begin
    a_d   = a_q;
    m_d   = m_q;
    e_d   = e_q;
    s_d   = s_q;
    z_d   = output_z;
    ack_d = input_a_ack;
    stb_d = output_z_stb;
    case (state_q)
      get_a: begin
        ack_d = 1'b1;
        if (a_take) begin
          a_d   = input_a;
          ack_d = 1'b0;
        end
      end
      unpack: begin
        m_d = {1'b1, a_q[DOUBLE_MANT_W-1:0], 11'b0};
        e_d = unbias(a_q[DOUBLE_W-2 -: DOUBLE_EXP_W]);
        s_d = a_q[DOUBLE_W-1];
      end
      special_cases: begin
        if (exit_zero) begin
          z_d = '0;
        end else if (exit_ovf) begin
          z_d = LONG_MIN;
        end else begin
          // First alignment step is taken here, so the serial loop reaches
          // e==63 one cycle earlier and e==62 can go straight to pack.
          m_d = m_q >> 1;
          e_d = e_q + 12'sd1;
        end
      end
      convert: begin
        m_d = m_q >> 1;
        e_d = e_q + 12'sd1;
      end
      pack: begin
        z_d   = s_q ? -m_q : m_q;
        stb_d = 1'b1;
      end
      put_z: begin
        stb_d = 1'b1;
        if (z_give) stb_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q          <= '0;
      m_q          <= '0;
      e_q          <= '0;
      s_q          <= 1'b0;
      output_z     <= '0;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
    end else begin
      a_q          <= a_d;
      m_q          <= m_d;
      e_q          <= e_d;
      s_q          <= s_d;
      output_z     <= z_d;
      input_a_ack  <= ack_d;
      output_z_stb <= stb_d;
    end
  end

endmodule

// File: tb/tb_double_to_long.sv
// Self-checking bench for double_to_long: directed vectors, a stalled stream,
// mid-conversion reset and random operands against a real-arithmetic model.
module tb_double_to_long;

  localparam logic [63:0] LMIN   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] D_ONE  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D_HUND = 64'h4059_0000_0000_0000;
  localparam logic [63:0] D_NEG1 = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] D_TWO  = 64'h4000_0000_0000_0000;

  logic        clk;
  logic        rst;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int total = 0;
  int bad   = 0;

  double_to_long dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // C-cast semantics via real arithmetic; out-of-range, Inf and NaN give LONG_MIN
  function automatic logic [63:0] model_z(input logic [63:0] a);
    real x, lim, t;
    x   = $bitstoreal(a);
    lim = 2.0 ** 63;
    if (a[62:52] == 11'h7FF) return LMIN;
    if (x >= lim || x <= -lim) return LMIN;
    t = (x < 0.0) ? $ceil(x) : $floor(x);
    return 64'(longint'(t));
  endfunction

  // Transfer-to-stb latency: 3 for early exits, 65-E otherwise
  function automatic int model_lat(input logic [63:0] a);
    int e;
    e = int'(a[62:52]) - 1023;
    if (a[62:52] == 11'd0 || e < 0 || e >= 63) return 3;
    return 65 - e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [63:0] a);
    int n;
    n = 0;
    input_a     = a;
    input_a_stb = 1'b1;
    while (input_a_ack !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_wait", 64'(input_a_ack), 64'd1);
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    chk("ack_drop", 64'(input_a_ack), 64'd0);
  endtask

  task automatic recv(input int stall, output logic [63:0] z, output int lat);
    bit busy, unstable;
    busy     = 1'b0;
    unstable = 1'b0;
    lat      = 0;
    while (output_z_stb !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (input_a_ack !== 1'b0) busy = 1'b1;
    end
    chk("stb_rise", 64'(output_z_stb), 64'd1);
    chk("busy_ack", 64'(busy), 64'd0);
    z = output_z;
    output_z_ack = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (output_z !== z || output_z_stb !== 1'b1 || input_a_ack !== 1'b0) unstable = 1'b1;
    end
    if (stall > 0) chk("stall_hold", 64'(unstable), 64'd0);
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    chk("stb_drop", 64'(output_z_stb), 64'd0);
  endtask

  task automatic xfer(input string tag, input logic [63:0] a, input logic [63:0] exp_z, input int stall);
    logic [63:0] z;
    int          lat;
    send(a);
    recv(stall, z, lat);
    chk({tag, ":z"}, z, exp_z);
    chk({tag, ":lat"}, 64'(lat), 64'(model_lat(a)));
  endtask

  initial begin
    logic [63:0] z;
    logic [63:0] ra;
    int          lat;
    bit          stale;

    rst          = 1'b1;
    input_a      = '0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(input_a_ack), 64'd0);
    chk("rst_stb", 64'(output_z_stb), 64'd0);
    chk("rst_z", output_z, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    xfer("one",     D_ONE,                  64'd1,                  0);
    chk("one_lat65", 64'(model_lat(D_ONE)), 64'd65);
    xfer("m2p5",    64'hC004_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    xfer("p075",    64'h3FE8_0000_0000_0000, 64'd0,                  0);
    xfer("negzero", 64'h8000_0000_0000_0000, 64'd0,                  0);
    xfer("denorm",  64'h0000_0000_0000_0001, 64'd0,                  0);
    xfer("maxfit",  64'h43DF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FC00, 0);
    xfer("p2_63",   64'h43E0_0000_0000_0000, LMIN,                   0);
    xfer("m2_63",   64'hC3E0_0000_0000_0000, LMIN,                   0);
    xfer("pinf",    64'h7FF0_0000_0000_0000, LMIN,                   0);
    xfer("ninf",    64'hFFF0_0000_0000_0000, LMIN,                   0);
    xfer("nan",     64'h7FF8_0000_0000_0000, LMIN,                   0);

    // Back-to-back stream; next operand waits with stb high while busy
    send(D_ONE);
    input_a = D_HUND; input_a_stb = 1'b1;
    recv(0, z, lat);
    chk("s1:z", z, 64'd1);
    send(D_HUND);
    input_a = D_NEG1; input_a_stb = 1'b1;
    recv(5, z, lat);
    chk("s2:z", z, 64'd100);
    send(D_NEG1);
    recv(0, z, lat);
    chk("s3:z", z, 64'hFFFF_FFFF_FFFF_FFFF);

    // Asynchronous reset in the middle of converting 1.0
    send(D_ONE);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_ack", 64'(input_a_ack), 64'd0);
    chk("arst_stb", 64'(output_z_stb), 64'd0);
    chk("arst_z", output_z, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    stale = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (output_z_stb !== 1'b0) stale = 1'b1;
    end
    chk("no_stale", 64'(stale), 64'd0);
    xfer("two", D_TWO, 64'd2, 0);

    // Random operands against the model
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      if (i % 4 != 0) ra[62:52] = 11'($urandom_range(1018, 1088));
      xfer("rand", ra, model_z(ra), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
